vref_trim_ctrl: RTL



---
 rtl/vref_trim_ctrl_if.sv | 28 ++
 rtl/vref_trim_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/vref_trim_ctrl_if.sv
// Control and status bundle between the bandgap trim controller and its driver.
// The master side issues requests and supplies the comparator; the slave is the controller.
interface vref_trim_ctrl_if #(
  parameter int TRIM_W   = 8,
  parameter int SETTLE_W = 8
);
  logic                start;
  logic                stop;
  logic                mode;
  logic [TRIM_W-1:0]   man_trim;
  logic [SETTLE_W-1:0] settle;
  logic                comp_in;
  logic                bg_en;
  logic [TRIM_W-1:0]   trim;
  logic                busy;
  logic                done;
  logic                sat;

  modport master (
    output start, stop, mode, man_trim, settle, comp_in,
    input  bg_en, trim, busy, done, sat
  );

  modport slave (
    input  start, stop, mode, man_trim, settle, comp_in,
    output bg_en, trim, busy, done, sat
  );
endinterface

// File: rtl/vref_trim_ctrl.sv
// Bandgap trim controller: manual code load or SAR auto-trim against an external comparator.
// Define VREF_TRIM_AVG_EN for a 3-sample majority vote on each SAR decision.
module vref_trim_ctrl #(
  parameter int TRIM_W   = 8,
  parameter int SETTLE_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  vref_trim_ctrl_if.slave    bus
);

  localparam int IDX_W = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
  localparam logic [IDX_W-1:0]    IDX_MSB = IDX_W'(TRIM_W - 1);
  localparam logic [IDX_W-1:0]    IDX_ONE = IDX_W'(1'b1);
  localparam logic [SETTLE_W-1:0] CNT_ONE = SETTLE_W'(1'b1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ENABLE = 3'd1,
    ST_SET    = 3'd2,
    ST_WAIT   = 3'd3,
    ST_SAMPLE = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  state_e              state_q;
  logic [TRIM_W-1:0]   trim_q;
  logic [TRIM_W-1:0]   trim_smp_d;
  logic [IDX_W-1:0]    idx_q;
  logic [SETTLE_W-1:0] cnt_q;
  logic [SETTLE_W-1:0] cnt_load_d;
  logic                bg_en_q;
  logic                busy_q;
  logic                done_q;
  logic                sat_q;
  logic                sync1_q;
  logic                comp_s_q;
  logic                bit_clr_d;
  logic                smp_last_d;

`ifdef VREF_TRIM_AVG_EN
  logic [1:0]          smp_cnt_q;
  logic [1:0]          smp_hist_q;
`endif

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic is_rail(input logic [TRIM_W-1:0] code);
    return (code == {TRIM_W{1'b0}}) || (&code);
  endfunction

  // Two-flop synchronizer for the free-running comparator output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      comp_s_q <= 1'b0;
    end else begin
      sync1_q  <= bus.comp_in;
      comp_s_q <= sync1_q;
    end
  end

  // Settle reload value, SAR bit decision and the code it produces
  always_comb begin
    cnt_load_d = (bus.settle == {SETTLE_W{1'b0}}) ? {SETTLE_W{1'b0}} : (bus.settle - CNT_ONE);
`ifdef VREF_TRIM_AVG_EN
    bit_clr_d  = majority3(smp_hist_q[1], smp_hist_q[0], comp_s_q);
    smp_last_d = (smp_cnt_q == 2'd2);
`else
    bit_clr_d  = comp_s_q;
    smp_last_d = 1'b1;
`endif
    trim_smp_d = trim_q;
    if (bit_clr_d) begin
      trim_smp_d[idx_q] = 1'b0;
    end else begin
      trim_smp_d[idx_q] = trim_q[idx_q];
    end
  end

  // Sequencing FSM; stop overrides everything except reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      trim_q  <= {TRIM_W{1'b0}};
      idx_q   <= {IDX_W{1'b0}};
      cnt_q   <= {SETTLE_W{1'b0}};
      bg_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
`ifdef VREF_TRIM_AVG_EN
      smp_cnt_q  <= 2'd0;
      smp_hist_q <= 2'b00;
`endif
    end else if (bus.stop) begin
      state_q <= ST_IDLE;
      bg_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
`ifdef VREF_TRIM_AVG_EN
      smp_cnt_q <= 2'd0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            bg_en_q <= 1'b1;
            sat_q   <= 1'b0;
            if (bus.mode) begin
              trim_q  <= {TRIM_W{1'b0}};
              idx_q   <= IDX_MSB;
              cnt_q   <= cnt_load_d;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
              state_q <= ST_ENABLE;
            end else begin
              trim_q  <= bus.man_trim;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_ENABLE: begin
          if (cnt_q == {SETTLE_W{1'b0}}) begin
            state_q <= ST_SET;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ST_SET: begin
          trim_q[idx_q] <= 1'b1;
          cnt_q         <= cnt_load_d;
          state_q       <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_q == {SETTLE_W{1'b0}}) begin
            state_q <= ST_SAMPLE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ST_SAMPLE: begin
          if (smp_last_d) begin
            trim_q <= trim_smp_d;
`ifdef VREF_TRIM_AVG_EN
            smp_cnt_q <= 2'd0;
`endif
            if (idx_q == {IDX_W{1'b0}}) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              sat_q   <= is_rail(trim_smp_d);
              state_q <= ST_DONE;
            end else begin
              idx_q   <= idx_q - IDX_ONE;
              state_q <= ST_SET;
            end
          end else begin
`ifdef VREF_TRIM_AVG_EN
            // Oldest sample in bit 1, newest in bit 0; the third comes live from comp_s_q
            smp_hist_q <= {smp_hist_q[0], comp_s_q};
            smp_cnt_q  <= smp_cnt_q + 2'd1;
`endif
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.bg_en = bg_en_q;
  assign bus.trim  = trim_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sat   = sat_q;

endmodule
